// File: rtl/sha256_w_sched_ctrl_pkg.sv
// Shared SHA-256 message-schedule constants, sigma rotate/shift amounts and FSM state type.
package sha256_w_sched_ctrl_pkg;

  localparam int WORD_W         = 32;
  localparam int BLK_W          = 512;
  localparam int WIN_WORDS      = BLK_W / WORD_W;
  localparam int ROUNDS_DEFAULT = 64;
  localparam int IDX_W          = 6;

  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha256_w_expand_step.sv
// One SHA-256 schedule expansion: W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
module sha256_w_expand_step
  import sha256_w_sched_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] w_t,
  input  logic [WORD_W-1:0] w_t1,
  input  logic [WORD_W-1:0] w_t9,
  input  logic [WORD_W-1:0] w_t14,
  output logic [WORD_W-1:0] w_next
);

  logic [WORD_W-1:0] sig0;
  logic [WORD_W-1:0] sig1;

  assign sig0   = rotr(w_t1, S0_ROT_A) ^ rotr(w_t1, S0_ROT_B) ^ (w_t1 >> S0_SHR);
  assign sig1   = rotr(w_t14, S1_ROT_A) ^ rotr(w_t14, S1_ROT_B) ^ (w_t14 >> S1_SHR);
  // Carries beyond bit 31 fall off naturally at the 32-bit result width.
  assign w_next = sig1 + w_t9 + sig0 + w_t;

endmodule

// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 message schedule controller: accepts a 512-bit block and streams W[0..ROUNDS-1]
// over a valid/ready interface using a 16-word sliding window.
module sha256_w_sched_ctrl
  import sha256_w_sched_ctrl_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
)
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [BLK_W-1:0]  blk_data,
  input  logic              abort,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [IDX_W-1:0]  w_idx,
  output logic              w_last,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_t            state_reg;
  logic              w_valid_reg;
  logic              w_last_reg;
  logic [IDX_W-1:0]  w_idx_reg;
  logic [WORD_W-1:0] window_reg [WIN_WORDS];
  logic [WORD_W-1:0] shift_src  [WIN_WORDS];
  logic [WORD_W-1:0] w_new;
  logic              accept;
  logic              handshake;

  assign blk_ready = (state_reg == ST_IDLE) && !abort;
  assign accept    = blk_valid && blk_ready;
  // w_valid is only ever high in EMIT, so this handshake cannot fire in IDLE.
  assign handshake = w_valid_reg && w_ready;

  sha256_w_expand_step u_expand (
    .w_t    (window_reg[0]),
    .w_t1   (window_reg[1]),
    .w_t9   (window_reg[9]),
    .w_t14  (window_reg[14]),
    .w_next (w_new)
  );

  for (genvar gi = 0; gi < WIN_WORDS; gi++) begin : g_shift
    if (gi < WIN_WORDS - 1) begin : g_mid
      assign shift_src[gi] = window_reg[gi + 1];
    end else begin : g_top
      assign shift_src[gi] = w_new;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < WIN_WORDS; i++) window_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < WIN_WORDS; i++)
        window_reg[i] <= blk_data[BLK_W - 1 - WORD_W * i -: WORD_W];
    end else if (handshake && !abort) begin
      for (int i = 0; i < WIN_WORDS; i++) window_reg[i] <= shift_src[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= ST_IDLE;
      w_valid_reg <= 1'b0;
      w_idx_reg   <= '0;
      w_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg   <= ST_EMIT;
            w_valid_reg <= 1'b1;
            w_idx_reg   <= '0;
            w_last_reg  <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (abort) begin
            state_reg   <= ST_IDLE;
            w_valid_reg <= 1'b0;
            w_last_reg  <= 1'b0;
          end else if (handshake) begin
            if (w_last_reg) begin
              state_reg   <= ST_IDLE;
              w_valid_reg <= 1'b0;
              w_last_reg  <= 1'b0;
            end else begin
              w_idx_reg  <= w_idx_reg + 1'b1;
              w_last_reg <= (w_idx_reg == LAST_IDX - 1'b1);
            end
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          w_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign w_valid = w_valid_reg;
  assign w_idx   = w_idx_reg;
  assign w_last  = w_last_reg;
  assign w_data  = window_reg[0];
  assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sha256_w_sched_ctrl.sv
// Scoreboard bench for sha256_w_sched_ctrl: expected schedule words come from an
// independent reference expansion and are queued at each block accept.
module tb_sha256_w_sched_ctrl;

  logic         CLK = 1'b0;
  logic         RST;
  logic         abort;
  logic         w_ready;
  logic [511:0] blk_data;
  logic         blk_valid_a, blk_valid_b;
  logic         blk_ready_a, blk_ready_b;
  logic         w_valid_a, w_valid_b;
  logic [31:0]  w_data_a, w_data_b;
  logic [5:0]   w_idx_a, w_idx_b;
  logic         w_last_a, w_last_b;
  logic         busy_a, busy_b;

  always #5 CLK = ~CLK;

  sha256_w_sched_ctrl #(.ROUNDS(64)) dut_a (
    .CLK(CLK), .RST(RST), .blk_valid(blk_valid_a), .blk_ready(blk_ready_a),
    .blk_data(blk_data), .abort(abort), .w_valid(w_valid_a), .w_ready(w_ready),
    .w_data(w_data_a), .w_idx(w_idx_a), .w_last(w_last_a), .busy(busy_a)
  );

  sha256_w_sched_ctrl #(.ROUNDS(16)) dut_b (
    .CLK(CLK), .RST(RST), .blk_valid(blk_valid_b), .blk_ready(blk_ready_b),
    .blk_data(blk_data), .abort(abort), .w_valid(w_valid_b), .w_ready(w_ready),
    .w_data(w_data_b), .w_idx(w_idx_b), .w_last(w_last_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
    logic        last;
  } exp_t;

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};

  exp_t        exp_q[$];
  logic [31:0] ref_w [64];
  int          n_cmp = 0;
  int          n_mis = 0;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_ref(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) ref_w[t] = blk[511 - 32 * t -: 32];
    for (int t = 16; t < 64; t++)
      ref_w[t] = (ror(ref_w[t-2], 17) ^ ror(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
               + ref_w[t-7]
               + (ror(ref_w[t-15], 7) ^ ror(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
               + ref_w[t-16];
  endtask

  task automatic push_block(input int rounds);
    exp_t e;
    for (int t = 0; t < rounds; t++) begin
      e.idx  = 6'(t);
      e.data = ref_w[t];
      e.last = (t == rounds - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b = {b[479:0], 32'($urandom())};
    return b;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; abort = 1'b0; w_ready = 1'b0; blk_valid_a = 1'b0; blk_valid_b = 1'b0;
    blk_data = '0;
    tick; tick;
    n_cmp++;
    if ({w_valid_a, w_idx_a, w_last_a, busy_a, w_data_a, blk_ready_a} !== {1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 1'b1}) begin
      n_mis++;
      $display("FAIL reset_state got v=%0b idx=%0d last=%0b busy=%0b data=%08h rdy=%0b exp 0/0/0/0/0/1",
               w_valid_a, w_idx_a, w_last_a, busy_a, w_data_a, blk_ready_a);
    end
    RST = 1'b0;
    tick;
    $display("reset done");
  endtask

  task automatic test_abc;
    exp_t e;
    int   edges;
    logic [31:0] kval;
    bit   kchk;
    build_ref(ABC_BLK);
    blk_data = ABC_BLK; w_ready = 1'b1; blk_valid_a = 1'b1;
    n_cmp++;
    if (blk_ready_a !== 1'b1) begin
      n_mis++; $display("FAIL abc_blk_ready got=%0b exp=1", blk_ready_a);
    end
    tick;
    blk_valid_a = 1'b0;
    push_block(64);
    edges = 0;
    while (exp_q.size() > 0 && edges < 200) begin
      n_cmp++;
      if (w_valid_a !== 1'b1) begin
        n_mis++; $display("FAIL abc_valid_gap got=%0b exp=1 at cycle %0d", w_valid_a, edges);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if ({w_idx_a, w_data_a, w_last_a} !== {e.idx, e.data, e.last}) begin
        n_mis++;
        $display("FAIL abc_word got idx=%0d data=%08h last=%0b exp idx=%0d data=%08h last=%0b",
                 w_idx_a, w_data_a, w_last_a, e.idx, e.data, e.last);
      end
      kchk = 1'b1;
      case (e.idx)
        6'd16:   kval = 32'h61626380;
        6'd17:   kval = 32'h000F0000;
        6'd18:   kval = 32'h7DA86405;
        6'd63:   kval = 32'h12B1EDEB;
        default: begin kval = 32'h0; kchk = 1'b0; end
      endcase
      if (kchk) begin
        n_cmp++;
        if (w_data_a !== kval) begin
          n_mis++; $display("FAIL abc_known_W%0d got=%08h exp=%08h", e.idx, w_data_a, kval);
        end
      end
      tick;
      edges++;
    end
    n_cmp++;
    if (edges != 64 || exp_q.size() != 0) begin
      n_mis++; $display("FAIL abc_length got=%0d exp=64", edges);
    end
    n_cmp++;
    if ({w_valid_a, blk_ready_a, busy_a} !== 3'b010) begin
      n_mis++; $display("FAIL abc_end got v/rdy/busy=%0b%0b%0b exp=010", w_valid_a, blk_ready_a, busy_a);
    end
    exp_q.delete();
    $display("abc block: %0d words", edges);
  endtask

  task automatic test_backpressure;
    exp_t        e;
    int          cyc, stalls;
    bit          stall;
    logic [39:0] held;
    build_ref(ABC_BLK);
    blk_data = ABC_BLK; blk_valid_a = 1'b1;
    tick;
    blk_valid_a = 1'b0;
    push_block(64);
    cyc = 0; stalls = 0; stall = 1'b0; held = '0;
    while (exp_q.size() > 0 && cyc < 600) begin
      if (stall) begin
        n_cmp++;
        if ({w_valid_a, w_idx_a, w_data_a, w_last_a} !== held) begin
          n_mis++; $display("FAIL bp_stall_hold got=%010h exp=%010h", {w_valid_a, w_idx_a, w_data_a, w_last_a}, held);
        end
      end
      w_ready = 1'($urandom_range(0, 1));
      if (w_valid_a && w_ready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({w_idx_a, w_data_a, w_last_a} !== {e.idx, e.data, e.last}) begin
          n_mis++;
          $display("FAIL bp_word got idx=%0d data=%08h last=%0b exp idx=%0d data=%08h last=%0b",
                   w_idx_a, w_data_a, w_last_a, e.idx, e.data, e.last);
        end
        stall = 1'b0;
      end else begin
        held  = {w_valid_a, w_idx_a, w_data_a, w_last_a};
        stall = w_valid_a;
        stalls++;
      end
      tick;
      cyc++;
    end
    w_ready = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0 || w_valid_a !== 1'b0 || blk_ready_a !== 1'b1) begin
      n_mis++; $display("FAIL bp_complete left=%0d v=%0b rdy=%0b exp 0/0/1", exp_q.size(), w_valid_a, blk_ready_a);
    end
    exp_q.delete();
    $display("backpressure block: %0d cycles, %0d stalls", cyc, stalls);
  endtask

  task automatic test_abort;
    exp_t         e;
    bit           hit;
    logic [511:0] blk;
    blk = rand_blk();
    build_ref(blk);
    blk_data = blk; abort = 1'b1; blk_valid_a = 1'b1; w_ready = 1'b1;
    #1;
    n_cmp++;
    if (blk_ready_a !== 1'b0) begin
      n_mis++; $display("FAIL abort_idle_ready got=%0b exp=0", blk_ready_a);
    end
    tick;
    n_cmp++;
    if ({busy_a, w_valid_a} !== 2'b00) begin
      n_mis++; $display("FAIL abort_idle_accept got busy/v=%0b%0b exp=00", busy_a, w_valid_a);
    end
    abort = 1'b0;
    tick;
    blk_valid_a = 1'b0;
    push_block(64);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({w_valid_a, w_idx_a, w_data_a} !== {1'b1, e.idx, e.data}) begin
        n_mis++; $display("FAIL abort_word got v=%0b idx=%0d data=%08h exp v=1 idx=%0d data=%08h",
                          w_valid_a, w_idx_a, w_data_a, e.idx, e.data);
      end
      if (e.idx == 6'd20) hit = 1'b1;
      else tick;
    end
    abort = 1'b1;
    tick;
    n_cmp++;
    if ({w_valid_a, busy_a} !== 2'b00) begin
      n_mis++; $display("FAIL abort_emit got v/busy=%0b%0b exp=00", w_valid_a, busy_a);
    end
    abort = 1'b0;
    #1;
    n_cmp++;
    if (blk_ready_a !== 1'b1) begin
      n_mis++; $display("FAIL abort_ready_back got=%0b exp=1", blk_ready_a);
    end
    exp_q.delete();
    blk = rand_blk();
    build_ref(blk);
    blk_data = blk; blk_valid_a = 1'b1;
    tick;
    blk_valid_a = 1'b0;
    n_cmp++;
    if ({w_valid_a, w_idx_a, w_data_a} !== {1'b1, 6'd0, ref_w[0]}) begin
      n_mis++; $display("FAIL abort_restart got v=%0b idx=%0d data=%08h exp v=1 idx=0 data=%08h",
                        w_valid_a, w_idx_a, w_data_a, ref_w[0]);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    $display("abort block: aborted at t=20, restart W0=%08h", ref_w[0]);
  endtask

  task automatic test_rst_mid_block;
    exp_t         e;
    bit           hit;
    logic [511:0] blk, blk2;
    blk = rand_blk();
    blk2 = rand_blk();
    build_ref(blk);
    blk_data = blk; blk_valid_a = 1'b1; w_ready = 1'b1;
    tick;
    blk_valid_a = 1'b0;
    push_block(64);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({w_idx_a, w_data_a} !== {e.idx, e.data}) begin
        n_mis++; $display("FAIL rst_pre_word got idx=%0d data=%08h exp idx=%0d data=%08h",
                          w_idx_a, w_data_a, e.idx, e.data);
      end
      if (e.idx == 6'd40) hit = 1'b1;
      else tick;
    end
    RST = 1'b1; blk_valid_a = 1'b1; blk_data = blk2;
    tick;
    n_cmp++;
    if ({w_valid_a, w_idx_a, w_last_a, busy_a, w_data_a} !== 41'd0) begin
      n_mis++; $display("FAIL rst_outputs got v=%0b idx=%0d last=%0b busy=%0b data=%08h exp all 0",
                        w_valid_a, w_idx_a, w_last_a, busy_a, w_data_a);
    end
    tick;
    n_cmp++;
    if ({w_valid_a, busy_a} !== 2'b00) begin
      n_mis++; $display("FAIL rst_held got v/busy=%0b%0b exp=00", w_valid_a, busy_a);
    end
    RST = 1'b0;
    tick;
    blk_valid_a = 1'b0;
    n_cmp++;
    if ({w_valid_a, w_idx_a, w_data_a} !== {1'b1, 6'd0, blk2[511:480]}) begin
      n_mis++; $display("FAIL rst_reaccept got v=%0b idx=%0d data=%08h exp v=1 idx=0 data=%08h",
                        w_valid_a, w_idx_a, w_data_a, blk2[511:480]);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    exp_q.delete();
    $display("rst block: reset at t=40, reaccepted W0=%08h", blk2[511:480]);
  endtask

  task automatic test_rounds16;
    exp_t         e;
    int           edges;
    logic [511:0] blk;
    blk = rand_blk();
    build_ref(blk);
    blk_data = blk; blk_valid_b = 1'b1; w_ready = 1'b1;
    tick;
    blk_valid_b = 1'b0;
    push_block(16);
    edges = 0;
    while (exp_q.size() > 0 && edges < 100) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({w_valid_b, busy_b, w_idx_b, w_data_b, w_last_b} !== {1'b1, 1'b1, e.idx, e.data, e.last}) begin
        n_mis++; $display("FAIL r16_word got v=%0b idx=%0d data=%08h last=%0b exp v=1 idx=%0d data=%08h last=%0b",
                          w_valid_b, w_idx_b, w_data_b, w_last_b, e.idx, e.data, e.last);
      end
      tick;
      edges++;
    end
    n_cmp++;
    if (edges + 1 != 17 || blk_ready_b !== 1'b1 || w_valid_b !== 1'b0) begin
      n_mis++; $display("FAIL r16_end got cycles=%0d rdy=%0b v=%0b exp cycles=17 rdy=1 v=0",
                        edges + 1, blk_ready_b, w_valid_b);
    end
    exp_q.delete();
    $display("rounds16 block: %0d words", edges);
  endtask

  task automatic test_back_to_back;
    exp_t         e;
    int           edges;
    logic [511:0] blks [2];
    blks[0] = rand_blk();
    blks[1] = rand_blk();
    w_ready = 1'b1;
    blk_valid_a = 1'b1;
    for (int b = 0; b < 2; b++) begin
      build_ref(blks[b]);
      blk_data = blks[b];
      tick;
      push_block(64);
      if (b == 0) blk_data = blks[1];
      else blk_valid_a = 1'b0;
      edges = 0;
      while (exp_q.size() > 0 && edges < 200) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({w_valid_a, w_idx_a, w_data_a, w_last_a} !== {1'b1, e.idx, e.data, e.last}) begin
          n_mis++; $display("FAIL b2b_word blk=%0d got v=%0b idx=%0d data=%08h last=%0b exp v=1 idx=%0d data=%08h last=%0b",
                            b, w_valid_a, w_idx_a, w_data_a, w_last_a, e.idx, e.data, e.last);
        end
        tick;
        edges++;
      end
      n_cmp++;
      if (w_valid_a !== 1'b0 || blk_ready_a !== 1'b1 || edges != 64) begin
        n_mis++; $display("FAIL b2b_gap blk=%0d got v=%0b rdy=%0b words=%0d exp v=0 rdy=1 words=64",
                          b, w_valid_a, blk_ready_a, edges);
      end
      $display("back_to_back block %0d: %0d words", b, edges);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_abort();
    test_rst_mid_block();
    test_rounds16();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sha256_w_sched_ctrl.md
SHA256_W_SCHED_CTRL -- requirements
Module: sha256_w_sched_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 64: number of W words emitted per block; legal range 16..64.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port blk_valid, input, 1 bit: a 512-bit message block is offered.
REQ-005 SHALL have port blk_ready, output, 1 bit: the block can be accepted this cycle.
REQ-006 SHALL have port blk_data, input, 512 bits: message block; W0 in [511:480], W15 in [31:0].
REQ-007 SHALL have port abort, input, 1 bit: discard the current block.
REQ-008 SHALL have port w_valid, output, 1 bit: w_data holds a valid schedule word.
REQ-009 SHALL have port w_ready, input, 1 bit: the compression round consumes the word.
REQ-010 SHALL have port w_data, output, 32 bits: schedule word W[w_idx].
REQ-011 SHALL have port w_idx, output, 6 bits: index t of the current word.
REQ-012 SHALL have port w_last, output, 1 bit: the current word is the final word, t = ROUNDS-1.
REQ-013 SHALL have port busy, output, 1 bit: asserted in every state other than IDLE.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and EMIT.
REQ-015 SHALL drive blk_ready = (state == IDLE) && !abort.
REQ-016 SHALL, on blk_valid && blk_ready:
- load a 16-word window register from blk_data;
- clear the index counter;
- enter EMIT.
REQ-017 SHALL assert w_valid exactly one cycle after the accepting edge, with w_data = W0 and w_idx = 0.
REQ-018 SHALL drive w_data = window[0] in EMIT.
REQ-019 SHALL hold w_data, w_idx and w_last stable while w_valid && !w_ready.
REQ-020 SHALL, on each handshake (w_valid && w_ready):
- shift the window down one word;
- insert W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t] at the top;
- increment w_idx.
REQ-021 SHALL compute s0(x) = ROTR7 ^ ROTR18 ^ SHR3 and s1(x) = ROTR17 ^ ROTR19 ^ SHR10; all additions mod 2^32, carries discarded.
REQ-022 SHALL, on a handshake with w_last = 1, return to IDLE; blk_ready rises in the next cycle and w_valid is low in that cycle.
REQ-023 SHALL sustain one word per cycle while w_ready is held high, so a block occupies ROUNDS+1 cycles from acceptance to blk_ready reasserting.
REQ-024 SHALL, on abort in EMIT, enter IDLE on the next edge with w_valid low; abort takes priority over a same-cycle handshake.
REQ-025 SHALL NOT accept a block while abort is asserted in IDLE.
REQ-026 SHALL hold w_valid low in IDLE.
REQ-027 SHALL treat w_ready as don't-care in IDLE.
REQ-028 SHALL ignore blk_valid while in EMIT; there is no queuing of a second block.

Reset
REQ-029 SHALL, on RST high at a rising edge, force state IDLE, w_valid = 0, w_idx = 0, w_last = 0, busy = 0 and window = 0.
REQ-030 SHALL make RST win over every other input, including mid-block; no word is emitted afterwards until a new block is accepted.
REQ-031 SHALL drive w_data = 0 after reset until the first accept.

Structure
REQ-032 SHALL take SHA-256 constants (word width 32, block width 512, default ROUNDS) and the sigma rotate/shift amounts from the shared sha256 package.
REQ-033 SHALL place the one-word expansion (s0, s1, four-input add) in a combinational sub-module, sha256_w_expand_step.
REQ-034 SHALL keep the FSM, counter and window register in the top module.

Verification
REQ-035 SHALL cover the "abc" padded block (W0 = 0x61626380, W15 = 0x00000018) with w_ready = 1:
- words appear on consecutive cycles starting one cycle after accept;
- W16 = 0x61626380, W17 = 0x000F0000, W18 = 0x7DA86405, W63 = 0x12B1EDEB;
- w_last is high only at t = 63.
REQ-036 SHALL cover backpressure: with the same block and w_ready toggled at random, the sequence is identical to REQ-035 and w_data is stable during every stall cycle.
REQ-037 SHALL cover abort at t = 20 with w_ready = 1: w_valid is low on the next cycle, blk_ready rises, and a new block then restarts at W0.
REQ-038 SHALL cover RST asserted at t = 40: all outputs reach their reset values after that edge, and blk_valid held throughout is accepted one cycle after RST falls.
REQ-039 SHALL cover ROUNDS = 16: only W0..W15 pass through, w_last is at t = 15, and blk_ready reasserts 17 cycles after accept.
REQ-040 SHALL cover back-to-back blocks with blk_valid held high: the second accept occurs in the cycle after the final handshake, leaving a one-cycle w_valid gap.
